// File: rtl/tts_pkg.sv
// tts_pkg: shared types and constants for the truth table scanner.
//   state_t  - scanner FSM states
//   N_IN_DEF - default number of function inputs
//   SETTLE_DEF - default settle cycles per vector
//   tbl_w()  - truth table width (2^n) for n inputs
package tts_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FINISH} state_t;

    localparam int N_IN_DEF   = 3;
    localparam int SETTLE_DEF = 2;

    function automatic int tbl_w(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tts_settle_timer.sv
// tts_settle_timer: loadable 4-bit down-counter with zero flag.
//   clk, rst_n - clock, async active-low reset
//   load       - load count with load_val (wins over en)
//   en         - decrement while nonzero
//   load_val   - value loaded on load
//   zero       - high when count is 0
module tts_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (load) count <= load_val;
        else if (en && !zero) count <= count - 1'b1;
    end

    assign zero = count == '0;

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: steps a combinational block through all input vectors and checks its truth table.
//   clk, rst_n - clock, async active-low reset
//   start      - begin a scan (IDLE only), abort - abandon scan (wins over start)
//   expected   - golden table, latched on accepted start
//   fn_in      - vector driven to the block, fn_out - block output
//   busy, done - scan in progress / one-cycle completion pulse
//   table_out, err_count, first_err, pass - captured table and comparison results
module truth_table_scanner
    import tts_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [tbl_w(N_IN)-1:0]   expected,
    output logic [N_IN-1:0]          fn_in,
    input  logic                     fn_out,
    output logic                     busy,
    output logic                     done,
    output logic [tbl_w(N_IN)-1:0]   table_out,
    output logic [N_IN:0]            err_count,
    output logic [N_IN-1:0]          first_err,
    output logic                     pass
);

    localparam int W = tbl_w(N_IN);

    state_t          state, state_nx;
    logic [N_IN:0]   idx;
    logic [W-1:0]    exp_q;
    logic            t_load, t_zero, mism, last;

    // idx carries one extra bit so the last-vector compare cannot alias a wrap
    assign mism = fn_out != exp_q[idx[N_IN-1:0]];
    assign last = idx == (N_IN+1)'(W-1);
    assign busy = state == APPLY || state == SAMPLE;
    assign done = state == FINISH;

    tts_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .en       (state == APPLY),
        .load_val (4'(SETTLE-1)),
        .zero     (t_zero)
    );

    always_comb begin
        state_nx = state;
        t_load   = 1'b0;
        unique case (state)
            IDLE:   if (start) begin state_nx = APPLY; t_load = 1'b1; end
            APPLY:  if (t_zero) state_nx = SAMPLE;
            SAMPLE: begin state_nx = last ? FINISH : APPLY; t_load = !last; end
            FINISH: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
            t_load   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            exp_q     <= '0;
            fn_in     <= '0;
            table_out <= '0;
            err_count <= '0;
            first_err <= '0;
            pass      <= 1'b0;
        end else begin
            state <= state_nx;
            if (abort) begin
                if (state != IDLE) fn_in <= '0;
            end else if (state == IDLE && start) begin
                exp_q     <= expected;
                idx       <= '0;
                fn_in     <= '0;
                table_out <= '0;
                err_count <= '0;
                first_err <= '0;
                pass      <= 1'b0;
            end else if (state == SAMPLE) begin
                table_out[idx[N_IN-1:0]] <= fn_out;
                if (mism) begin
                    err_count <= err_count + 1'b1;
                    if (err_count == '0) first_err <= idx[N_IN-1:0];
                end
                if (last) pass <= err_count == '0 && !mism;
                else begin
                    idx   <= idx + 1'b1;
                    fn_in <= N_IN'(idx + 1'b1);
                end
            end
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: self-checking bench for truth_table_scanner (SETTLE = 2, 1, 4 instances).
module tb_truth_table_scanner;

    typedef struct {
        logic [7:0] tbl;
        logic [3:0] err;
        logic [2:0] first;
        logic       pass;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] start = '0;
    logic [2:0] abort = '0;
    logic [2:0][7:0] expected = '0;
    wire  [2:0] fn_out, busy, done, pass;
    wire  [2:0][7:0] table_out;
    wire  [2:0][2:0] fn_in, first_err;
    wire  [2:0][3:0] err_count;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic f1(input logic [2:0] v);
        return (!v[2] && !v[0]) || (v[1] && v[0]) || (v[2] && !v[1]);
    endfunction

    function automatic exp_t model(input logic [7:0] e, input int settle);
        exp_t x;
        logic [7:0] d;
        for (int k = 0; k < 8; k++) x.tbl[k] = f1(3'(k));
        d = x.tbl ^ e;
        x.err = 4'($countones(d));
        x.first = 3'd0;
        for (int k = 7; k >= 0; k--) if (d[k]) x.first = 3'(k);
        x.pass = x.err == 0;
        x.lat = 8 * (settle + 1) + 1;
        return x;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        truth_table_scanner #(.N_IN(3), .SETTLE(g == 0 ? 2 : (g == 1 ? 1 : 4))) u (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .abort     (abort[g]),
            .expected  (expected[g]),
            .fn_in     (fn_in[g]),
            .fn_out    (fn_out[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .table_out (table_out[g]),
            .err_count (err_count[g]),
            .first_err (first_err[g]),
            .pass      (pass[g])
        );
        assign fn_out[g] = f1(fn_in[g]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scan(input int i, input logic [7:0] e, input bit hold, input bit vec);
        exp_t x;
        int n, run, settle;
        logic [2:0] cur;
        bit got;
        settle = i == 0 ? 2 : (i == 1 ? 1 : 4);
        @(negedge clk);
        expected[i] = e;
        start[i] = 1'b1;
        sb.push_back(model(e, settle));
        n = 0; run = 0; cur = '0; got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (!hold) start[i] = 1'b0;
            if (n == 1) chk("busy_rise", busy[i], 1);
            if (vec) begin
                if (n == 1) begin
                    chk("vec_first", fn_in[i], 0);
                    cur = fn_in[i];
                    run = 1;
                end else if (fn_in[i] != cur) begin
                    chk("vec_hold", run, settle + 1);
                    chk("vec_order", fn_in[i], cur + 1);
                    cur = fn_in[i];
                    run = 1;
                end else run++;
            end
            got = done[i];
        end
        start[i] = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
        x = sb.pop_front();
        chk("table_out", table_out[i], x.tbl);
        chk("err_count", err_count[i], x.err);
        chk("first_err", first_err[i], x.first);
        chk("pass", pass[i], x.pass);
        chk("latency", n, x.lat);
        chk("busy_at_done", busy[i], 0);
        if (vec) chk("vec_last", cur, 7);
        @(posedge clk); #1;
        chk("done_pulse", done[i], 0);
        chk("idle_busy", busy[i], 0);
    endtask

    initial begin
        int n, cnt;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_pass", pass[0], 0);
        chk("rst_table", table_out[0], 0);
        chk("rst_err", err_count[0], 0);
        chk("rst_first", first_err[0], 0);
        chk("rst_fn_in", fn_in[0], 0);
        @(negedge clk);
        rst_n = 1'b1;

        scan(0, 8'hBD, 1'b0, 1'b1);
        scan(0, 8'hBF, 1'b0, 1'b0);
        scan(0, 8'h00, 1'b0, 1'b0);
        scan(1, 8'hBD, 1'b0, 1'b1);
        scan(2, 8'hBD, 1'b0, 1'b1);

        @(negedge clk);
        expected[0] = 8'hBD;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        n = 0;
        while (fn_in[0] != 3'd4 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reach_v4", fn_in[0], 4);
        @(negedge clk);
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        chk("abort_busy", busy[0], 0);
        chk("abort_fn_in", fn_in[0], 0);
        chk("abort_table_lo", table_out[0][3:0], 4'hD);
        cnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done[0]) cnt++;
        end
        chk("abort_no_done", cnt, 0);

        @(negedge clk);
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        abort[0] = 1'b0;
        chk("abort_start_idle", busy[0], 0);

        scan(0, 8'hBD, 1'b0, 1'b1);

        scan(0, 8'hBF, 1'b1, 1'b0);
        cnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (busy[0]) cnt++;
        end
        chk("held_start_one_scan", cnt, 0);

        @(negedge clk);
        expected[0] = 8'hBD;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_busy", busy[0], 1);
        chk("pre_rst_table2", table_out[2], 8'hBD);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy[0], 0);
        chk("arst_done", done[0], 0);
        chk("arst_fn_in", fn_in[0], 0);
        chk("arst_table2", table_out[2], 0);
        chk("arst_pass2", pass[2], 0);
        chk("arst_err0", err_count[0], 0);
        @(negedge clk);
        rst_n = 1'b1;

        scan(0, 8'hBD, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
